bram_pingpong_ctrl: RTL

BRAM_PINGPONG_CTRL -- requirements
Module: bram_pingpong_ctrl

---
 rtl/bram_pingpong_ctrl_pkg.sv | 22 ++
 rtl/block_ram_simple_dual_port.sv | 39 +++
 rtl/bram_pingpong_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bram_pingpong_ctrl_pkg.sv
// Shared bank-state encoding and address-width helper for the ping-pong controller.
package bram_pingpong_ctrl_pkg;

    localparam logic [1:0] BANK_EMPTY    = 2'd0;
    localparam logic [1:0] BANK_FILLING  = 2'd1;
    localparam logic [1:0] BANK_FULL     = 2'd2;
    localparam logic [1:0] BANK_DRAINING = 2'd3;

    // Bits needed to address 'value' locations (minimum 1).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned w;
        v = (value > 1) ? value - 1 : 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/block_ram_simple_dual_port.sv
// Simple dual-port block RAM: port A writes, port B reads with one cycle of latency.
module block_ram_simple_dual_port
    import bram_pingpong_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = clogb2(DEPTH)
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  clkb,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] doutb_q;

    // Write port; contents are never reset.
    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem_q[addra] <= dina;
        end
    end

    // Read port; output register holds while enb is low.
    always_ff @(posedge clkb) begin
        if (enb) begin
            doutb_q <= mem_q[addrb];
        end
    end

    assign doutb = doutb_q;

endmodule

// File: rtl/bram_pingpong_ctrl.sv
// Two-bank ping-pong frame buffer: one bank fills while the other drains.
module bram_pingpong_ctrl
    import bram_pingpong_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 256,
    parameter int unsigned FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  frame_done,
    output logic [1:0]            bank_full
);

    localparam int unsigned AW = clogb2(DATA_DEPTH);
    // Read counter needs one extra bit to express "all FRAME_LEN words issued".
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] WR_LAST = AW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] RD_END  = CW'(FRAME_LEN);

    logic [1:0][1:0] bank_st_q, bank_st_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic            rd_src_q, rd_src_d;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic            frame_done_q, frame_done_d;

    logic            wr_fire;
    logic            rd_accept;
    logic            rd_issue;
    logic [1:0]      ram_we;
    logic [1:0]      ram_re;
    logic [DATA_WIDTH-1:0] ram_dout [2];

    // Handshakes and per-bank RAM enables.
    always_comb begin
        wr_ready  = !clear && (bank_st_q[wr_bank_q] == BANK_EMPTY ||
                               bank_st_q[wr_bank_q] == BANK_FILLING);
        wr_fire   = wr_valid && wr_ready;
        rd_accept = rd_valid_q && rd_ready && !clear;
        rd_issue  = !clear && (bank_st_q[rd_bank_q] == BANK_DRAINING) &&
                    (rd_cnt_q != RD_END) && (!rd_valid_q || rd_ready);
        ram_we            = 2'b00;
        ram_re            = 2'b00;
        ram_we[wr_bank_q] = wr_fire;
        ram_re[rd_bank_q] = rd_issue;
    end

    // Next-state for bank states, pointers, counters and read-side outputs.
    always_comb begin
        bank_st_d    = bank_st_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        rd_src_d     = rd_src_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        frame_done_d = 1'b0;

        // Writes never target a FULL/DRAINING bank, so they cannot collide with read-side updates.
        if (wr_fire) begin
            if (wr_cnt_q == WR_LAST) begin
                bank_st_d[wr_bank_q] = BANK_FULL;
                wr_cnt_d             = '0;
                wr_bank_d            = ~wr_bank_q;
            end else begin
                bank_st_d[wr_bank_q] = BANK_FILLING;
                wr_cnt_d             = wr_cnt_q + 1'b1;
            end
        end

        if (bank_st_q[rd_bank_q] == BANK_FULL) begin
            bank_st_d[rd_bank_q] = BANK_DRAINING;
            rd_cnt_d             = '0;
        end

        if (rd_issue) begin
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_cnt_q == RD_LAST);
            rd_cnt_d   = rd_cnt_q + 1'b1;
            rd_src_d   = rd_bank_q;
        end else if (rd_accept) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        if (rd_accept && rd_last_q) begin
            bank_st_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d            = ~rd_bank_q;
            frame_done_d         = 1'b1;
        end

        // Soft flush overrides every same-cycle handshake.
        if (clear) begin
            bank_st_d    = {BANK_EMPTY, BANK_EMPTY};
            wr_bank_d    = 1'b0;
            rd_bank_d    = 1'b0;
            rd_src_d     = 1'b0;
            wr_cnt_d     = '0;
            rd_cnt_d     = '0;
            rd_valid_d   = 1'b0;
            rd_last_d    = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_q    <= {BANK_EMPTY, BANK_EMPTY};
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_src_q     <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            bank_st_q    <= bank_st_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            rd_src_q     <= rd_src_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // One RAM per bank, both on the single system clock.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        block_ram_simple_dual_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DATA_DEPTH),
            .ADDR_WIDTH (AW)
        ) u_ram (
            .clka  (clk),
            .ena   (ram_we[g]),
            .wea   (1'b1),
            .addra (wr_cnt_q),
            .dina  (wr_data),
            .clkb  (clk),
            .enb   (ram_re[g]),
            .addrb (rd_cnt_q[AW-1:0]),
            .doutb (ram_dout[g])
        );
    end

    assign rd_data    = rd_src_q ? ram_dout[1] : ram_dout[0];
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign frame_done = frame_done_q;
    // FULL and DRAINING are the two encodings with the upper bit set.
    assign bank_full  = {bank_st_q[1][1], bank_st_q[0][1]};

endmodule
